dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array; SHALL be a power of two, at least 4.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 rst_ni  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 dmem_addr_i  input  32  byte address from core.
REQ-005 dmem_data_i  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-006 dmem_rd_en_i  input  1  load request, valid this cycle.
REQ-007 dmem_wr_en_i  input  1  store request, valid this cycle.
REQ-008 dmem_size_i  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 dmem_sign_i  input  1  load extension: 1 signed, 0 unsigned; ignored for stores and words.
REQ-010 dmem_data_o  output  32  aligned, extended load data.
REQ-011 dmem_rvalid_o  output  1  dmem_data_o holds a completed load.
REQ-012 fault_o  output  1  one-cycle pulse: previous-cycle request faulted.
REQ-013 fault_cnt_o  output  8  saturating count of faulted requests.

Function
REQ-014 Load latency SHALL be exactly 1 cycle: request at edge N -> dmem_data_o/dmem_rvalid_o valid after edge N+1, held until the next edge.
REQ-015 dmem_rvalid_o SHALL be 0 in any cycle not following an accepted load; dmem_data_o SHALL then be 0.
REQ-016 Stores SHALL commit at the edge ending the request cycle; no response other than fault_o.
REQ-017 Byte lane = addr[1:0]; store write-enables: byte -> 1 lane, halfword -> lanes addr[1]*2 and +1, word -> all 4; data replicated to the selected lanes.
REQ-018 Load extraction SHALL use a registered copy of addr[1:0], size and sign; byte/half zero- or sign-extended per sign; words are returned unchanged.
REQ-019 Word index = addr[31:2]; index >= DEPTH_WORDS SHALL be an out-of-range fault.
REQ-020 Misaligned faults: halfword with addr[0]=1; word with addr[1:0]!=0; size 11 in any case.
REQ-021 rd_en and wr_en both high SHALL be a fault.
REQ-022 A faulted request SHALL NOT modify the array. A faulted load SHALL return dmem_data_o=0 with dmem_rvalid_o=1. fault_o SHALL pulse in the same cycle the load response would be valid.
REQ-023 fault_cnt_o SHALL increment once per faulted request and saturate at 255.
REQ-024 A load in cycle N+1 SHALL observe a store to the same word committed in cycle N.
REQ-025 No request (both enables low) SHALL leave the array and fault_cnt_o unchanged.

Reset
REQ-026 While rst_ni=0: dmem_data_o=0, dmem_rvalid_o=0, fault_o=0, fault_cnt_o=0; registered offset/size/sign SHALL be cleared.
REQ-027 Array contents SHALL NOT be reset and SHALL persist across reset.
REQ-028 A request in flight when reset asserts SHALL be discarded, with no response after release.
REQ-029 The first request SHALL be accepted on the first edge after rst_ni deasserts.

Structure
REQ-030 A shared package SHALL hold the dmem_size_t enum (SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10) used by both core and responder.
REQ-031 Sub-module dmem_ram SHALL implement DEPTH_WORDS x 32 synchronous RAM: 4 byte write-enables, registered read, no reset.
REQ-032 Fault detection, lane steering and load extension SHALL live in dmem_responder.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> dmem_data_o=0xDEADBEEF, rvalid one cycle after the load.
REQ-034 After REQ-033: LB @0x13 signed -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-035 SB 0x55 @0x11, then LW @0x10 next cycle -> 0xDEAD55EF.
REQ-036 LW @0x12, SH @0x11, size 11 @0x0 -> each: fault_o pulse, data 0 for the load, array unchanged; fault_cnt_o=3.
REQ-037 With DEPTH_WORDS=1024: SW @0x1000 -> fault, no write; LW @0x0FFC -> valid data, no fault.
REQ-038 Assert rst_ni=0 in the cycle after an LW: no rvalid after release, fault_cnt_o=0, prior array contents still readable.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory port.
// Used by the core side and by dmem_responder / dmem_ram.
//   dmem_size_t : access size encoding carried on dmem_size_i
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11   // never legal; any request using it faults
   } dmem_size_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between a core and the responder.
//   master modport : core side (drives request, receives response)
//   slave modport  : responder side
// Signal names keep the responder's point of view (_i into, _o out of it).
interface dmem_responder_if;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_data_i;
   logic        dmem_rd_en_i;
   logic        dmem_wr_en_i;
   logic [1:0]  dmem_size_i;
   logic        dmem_sign_i;
   logic [31:0] dmem_data_o;
   logic        dmem_rvalid_o;
   logic        fault_o;
   logic [7:0]  fault_cnt_o;

   modport master (
      output dmem_addr_i, dmem_data_i, dmem_rd_en_i, dmem_wr_en_i,
             dmem_size_i, dmem_sign_i,
      input  dmem_data_o, dmem_rvalid_o, fault_o, fault_cnt_o
   );

   modport slave (
      input  dmem_addr_i, dmem_data_i, dmem_rd_en_i, dmem_wr_en_i,
             dmem_size_i, dmem_sign_i,
      output dmem_data_o, dmem_rvalid_o, fault_o, fault_cnt_o
   );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 synchronous RAM, one port, four byte write-enables.
//   clk      : clock
//   addr_i   : word index
//   we_i     : per-byte write enables (lane 0 = bits [7:0])
//   wdata_i  : write data, already steered to lanes
//   rdata_o  : registered read data (old contents on a write cycle)
// Contents are never reset so they survive a responder reset.
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_i,
   input  logic [3:0]    we_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   // One byte-wide array per lane keeps byte writes a plain inferred RAM.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] rdata_q;

      always_ff @(posedge clk) begin
         if (we_i[gi]) begin
            mem_q[addr_i] <= wdata_i[gi*8 +: 8];
         end
         rdata_q <= mem_q[addr_i];
      end

      assign rdata_o[gi*8 +: 8] = rdata_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder.
//   clk    : clock
//   rst_ni : asynchronous active-low reset
//   bus    : request/response bundle (slave side)
// Loads answer exactly one cycle after acceptance; stores commit at the
// edge ending the request cycle. Out-of-range, misaligned, reserved-size
// and simultaneous read/write requests fault: they never touch the array,
// pulse fault_o one cycle later, and bump a saturating counter.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_ni,
   dmem_responder_if.slave   bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_size_t  req_size;
   logic [1:0]  req_off;
   logic        misaligned;
   logic        out_of_range;
   logic        req_any;
   logic        req_fault;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [3:0]  ram_we;
   logic [31:0] ram_rdata;

   logic        rvalid_q;
   logic        fault_q;
   logic [1:0]  off_q;
   dmem_size_t  size_q;
   logic        sign_q;
   logic [7:0]  cnt_q;
   logic [31:0] load_ext;

   assign req_size     = dmem_size_t'(bus.dmem_size_i);
   assign req_off      = bus.dmem_addr_i[1:0];
   assign out_of_range = bus.dmem_addr_i[31:2] >= 30'(DEPTH_WORDS);
   assign req_any      = bus.dmem_rd_en_i | bus.dmem_wr_en_i;
   assign req_fault    = req_any & (out_of_range | misaligned |
                                    (bus.dmem_rd_en_i & bus.dmem_wr_en_i));

   // Alignment check and lane steering share the size decode.
   always_comb begin
      misaligned = 1'b0;
      lane_be    = 4'b0000;
      lane_wdata = bus.dmem_data_i;
      case (req_size)
         SIZE_BYTE: begin
            lane_be    = 4'b0001 << req_off;
            lane_wdata = {4{bus.dmem_data_i[7:0]}};
         end
         SIZE_HALF: begin
            misaligned = req_off[0];
            lane_be    = req_off[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{bus.dmem_data_i[15:0]}};
         end
         SIZE_WORD: begin
            misaligned = |req_off;
            lane_be    = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   assign ram_we = (bus.dmem_wr_en_i && !req_fault) ? lane_be : 4'b0000;

   // Out-of-range indices alias in the RAM, but their writes are gated
   // off above and their read data is masked below.
   dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk     (clk),
      .addr_i  (bus.dmem_addr_i[AW+1:2]),
      .we_i    (ram_we),
      .wdata_i (lane_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
         off_q    <= 2'b00;
         size_q   <= SIZE_BYTE;
         sign_q   <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         rvalid_q <= bus.dmem_rd_en_i;
         fault_q  <= req_fault;
         if (bus.dmem_rd_en_i) begin
            off_q  <= req_off;
            size_q <= req_size;
            sign_q <= bus.dmem_sign_i;
         end
         if (req_fault && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   // Extract and extend the loaded element from the registered word.
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b        = ram_rdata[{off_q, 3'b000} +: 8];
      h        = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      load_ext = 32'd0;
      case (size_q)
         SIZE_BYTE: load_ext = {{24{sign_q & b[7]}}, b};
         SIZE_HALF: load_ext = {{16{sign_q & h[15]}}, h};
         SIZE_WORD: load_ext = ram_rdata;
         default:   load_ext = 32'd0;
      endcase
   end

   assign bus.dmem_data_o   = (rvalid_q && !fault_q) ? load_ext : 32'd0;
   assign bus.dmem_rvalid_o = rvalid_q;
   assign bus.fault_o       = fault_q;
   assign bus.fault_cnt_o   = cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, random traffic
// against a byte-addressed memory model, and a reset-in-flight sequence.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH_WORDS(1024)) dut (
      .clk    (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: little-endian byte memory plus per-byte "written" flag.
   logic [7:0] mm [4096];
   bit         kn [4096];
   int         cnt_m = 0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [1:0]  size;
      bit          sign;
      logic [31:0] addr;
      logic [31:0] data;
      bit          e_rvalid;
      logic [31:0] e_data;
      bit          e_fault;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Applies one request to the model; returns expected response.
   task automatic model_step(input bit rd, input bit wr, input logic [1:0] size,
                             input bit sign, input logic [31:0] addr,
                             input logic [31:0] data,
                             output bit e_rvalid, output logic [31:0] e_data,
                             output bit e_fault, output bit e_known);
      int  nbytes;
      bit  mis, oor;
      logic [31:0] v;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      oor = addr >= 32'h1000;
      mis = (size == 2'd3) || (addr % nbytes != 0);
      e_fault  = (rd || wr) && (oor || mis || (rd && wr));
      e_rvalid = rd;
      e_data   = 32'd0;
      e_known  = 1'b1;
      if (rd && !e_fault) begin
         v = 32'd0;
         for (int k = 0; k < nbytes; k++) begin
            v = v | (32'(mm[addr + k]) << (8 * k));
            if (!kn[addr + k]) e_known = 1'b0;
         end
         if (sign && nbytes == 1 && v[7])  v = v | 32'hFFFF_FF00;
         if (sign && nbytes == 2 && v[15]) v = v | 32'hFFFF_0000;
         e_data = v;
      end
      if (wr && !e_fault) begin
         for (int k = 0; k < nbytes; k++) begin
            mm[addr + k] = data[8*k +: 8];
            kn[addr + k] = 1'b1;
         end
      end
      if (e_fault && cnt_m < 255) cnt_m++;
   endtask

   // Drive at negedge, let the edge accept it, sample at the next negedge.
   task automatic drive(input bit rd, input bit wr, input logic [1:0] size,
                        input bit sign, input logic [31:0] addr,
                        input logic [31:0] data);
      bus.dmem_rd_en_i = rd;
      bus.dmem_wr_en_i = wr;
      bus.dmem_size_i  = size;
      bus.dmem_sign_i  = sign;
      bus.dmem_addr_i  = addr;
      bus.dmem_data_i  = data;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.dmem_rd_en_i = 1'b0;
      bus.dmem_wr_en_i = 1'b0;
      bus.dmem_size_i  = 2'd0;
      bus.dmem_sign_i  = 1'b0;
      bus.dmem_addr_i  = 32'd0;
      bus.dmem_data_i  = 32'd0;
   endtask

   task automatic model_req(string tag, input bit rd, input bit wr,
                            input logic [1:0] size, input bit sign,
                            input logic [31:0] addr, input logic [31:0] data);
      bit er, ef, ek;
      logic [31:0] ed;
      drive(rd, wr, size, sign, addr, data);
      model_step(rd, wr, size, sign, addr, data, er, ed, ef, ek);
      chk({tag, " rvalid"}, 32'(bus.dmem_rvalid_o), 32'(er));
      chk({tag, " fault"},  32'(bus.fault_o), 32'(ef));
      chk({tag, " cnt"},    32'(bus.fault_cnt_o), 32'(cnt_m));
      if (ek) chk({tag, " data"}, bus.dmem_data_o, ed);
   endtask

   initial begin
      bit er, ef, ek;
      logic [31:0] ed;
      for (int i = 0; i < 4096; i++) begin
         mm[i] = 8'h00;
         kn[i] = 1'b0;
      end
      //          rd wr sz  sg addr          data          rv exp_data      ft cnt
      tbl[0]  = '{0, 1, 2'd2, 0, 32'h0000_0000, 32'hA5A5_A5A5, 0, 32'h0,        0, 8'd0};
      tbl[1]  = '{0, 1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,        0, 8'd0};
      tbl[2]  = '{1, 0, 2'd2, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF,0, 8'd0};
      tbl[3]  = '{1, 0, 2'd0, 1, 32'h0000_0013, 32'h0,         1, 32'hFFFF_FFDE,0, 8'd0};
      tbl[4]  = '{1, 0, 2'd0, 0, 32'h0000_0013, 32'h0,         1, 32'h0000_00DE,0, 8'd0};
      tbl[5]  = '{1, 0, 2'd1, 1, 32'h0000_0012, 32'h0,         1, 32'hFFFF_DEAD,0, 8'd0};
      tbl[6]  = '{1, 0, 2'd1, 0, 32'h0000_0010, 32'h0,         1, 32'h0000_BEEF,0, 8'd0};
      tbl[7]  = '{0, 1, 2'd0, 0, 32'h0000_0011, 32'h0000_0055, 0, 32'h0,        0, 8'd0};
      tbl[8]  = '{1, 0, 2'd2, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_55EF,0, 8'd0};
      tbl[9]  = '{1, 0, 2'd2, 0, 32'h0000_0012, 32'h0,         1, 32'h0,        1, 8'd1};
      tbl[10] = '{0, 1, 2'd1, 0, 32'h0000_0011, 32'h0000_1234, 0, 32'h0,        1, 8'd2};
      tbl[11] = '{0, 1, 2'd3, 0, 32'h0000_0010, 32'hFFFF_FFFF, 0, 32'h0,        1, 8'd3};
      tbl[12] = '{1, 0, 2'd2, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_55EF,0, 8'd3};
      tbl[13] = '{0, 1, 2'd2, 0, 32'h0000_1000, 32'h1111_1111, 0, 32'h0,        1, 8'd4};
      tbl[14] = '{1, 0, 2'd2, 0, 32'h0000_0000, 32'h0,         1, 32'hA5A5_A5A5,0, 8'd4};
      tbl[15] = '{0, 1, 2'd2, 0, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'h0,        0, 8'd4};
      tbl[16] = '{1, 0, 2'd2, 0, 32'h0000_0FFC, 32'h0,         1, 32'hCAFE_F00D,0, 8'd4};
      tbl[17] = '{1, 1, 2'd2, 0, 32'h0000_0000, 32'h0,         1, 32'h0,        1, 8'd5};
      tbl[18] = '{0, 0, 2'd0, 0, 32'h0000_0000, 32'h0,         0, 32'h0,        0, 8'd5};

      // Reset state.
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("reset rvalid", 32'(bus.dmem_rvalid_o), 32'd0);
      chk("reset data",   bus.dmem_data_o, 32'd0);
      chk("reset fault",  32'(bus.fault_o), 32'd0);
      chk("reset cnt",    32'(bus.fault_cnt_o), 32'd0);
      rst_ni = 1'b1;

      // Directed table; first request is accepted on the first edge after release.
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].sign, tbl[i].addr, tbl[i].data);
         model_step(tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].sign, tbl[i].addr,
                    tbl[i].data, er, ed, ef, ek);
         chk($sformatf("tbl%0d rvalid", i), 32'(bus.dmem_rvalid_o), 32'(tbl[i].e_rvalid));
         chk($sformatf("tbl%0d data", i),   bus.dmem_data_o, tbl[i].e_data);
         chk($sformatf("tbl%0d fault", i),  32'(bus.fault_o), 32'(tbl[i].e_fault));
         chk($sformatf("tbl%0d cnt", i),    32'(bus.fault_cnt_o), 32'(tbl[i].e_cnt));
         $display("[TB] tbl%0d rd=%0d wr=%0d size=%0d addr=%08h -> data=%08h rvalid=%0d fault=%0d cnt=%0d",
                  i, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].addr,
                  bus.dmem_data_o, bus.dmem_rvalid_o, bus.fault_o, bus.fault_cnt_o);
      end

      // Seed the random window with known words.
      for (int w = 0; w < 16; w++) begin
         model_req($sformatf("seed%0d", w), 1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
      end

      // Random traffic; enough faults to drive the counter into saturation.
      for (int t = 0; t < 1500; t++) begin
         int r, k;
         bit rd, wr;
         logic [31:0] addr;
         logic [1:0] size;
         r = $urandom_range(0, 99);
         rd = (r < 45) || (r >= 95);
         wr = (r >= 45 && r < 85) || (r >= 95);
         k = $urandom_range(0, 99);
         if (k < 85)      addr = 32'($urandom_range(0, 63));
         else if (k < 90) addr = 32'h0FFC + 32'($urandom_range(0, 3));
         else if (k < 96) addr = 32'h1000 + 32'($urandom_range(0, 255));
         else             addr = $urandom | 32'h8000_0000;
         size = 2'($urandom_range(0, 3));
         model_req($sformatf("rnd%0d", t), rd, wr, size, 1'($urandom), addr, $urandom);
         if (t % 100 == 0)
            $display("[TB] rnd%0d rd=%0d wr=%0d size=%0d addr=%08h -> data=%08h fault=%0d cnt=%0d",
                     t, rd, wr, size, addr, bus.dmem_data_o, bus.fault_o, bus.fault_cnt_o);
      end
      chk("cnt saturated", 32'(bus.fault_cnt_o), 32'd255);

      // Reset with a load response in flight.
      model_req("pre-rst sw", 1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1357_9BDF);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      rst_ni = 1'b0;
      idle_inputs();
      #1;
      chk("rst-inflight rvalid", 32'(bus.dmem_rvalid_o), 32'd0);
      chk("rst-inflight data",   bus.dmem_data_o, 32'd0);
      chk("rst-inflight cnt",    32'(bus.fault_cnt_o), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      cnt_m = 0;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      chk("post-rst rvalid", 32'(bus.dmem_rvalid_o), 32'd0);
      chk("post-rst fault",  32'(bus.fault_o), 32'd0);
      chk("post-rst cnt",    32'(bus.fault_cnt_o), 32'd0);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      chk("persist rvalid", 32'(bus.dmem_rvalid_o), 32'd1);
      chk("persist data",   bus.dmem_data_o, 32'h1357_9BDF);
      $display("[TB] post-reset lw @20 -> data=%08h rvalid=%0d", bus.dmem_data_o, bus.dmem_rvalid_o);
      idle_inputs();
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
